logic_unit_pipe: RTL and testbench
==================================

# logic_unit_pipe

- Parametrised, registered bitwise logic unit for the 8-bit microprocessor datapath; successor to the fixed 2-input AND gate implementations.
- Supports eight logic operations at configurable width behind a valid/ready handshake with a one-stage output register.
- Adds an accumulate mode that folds a multi-beat operand burst into one result (e.g. AND-reduce of a register list).
- Sits between the operand-fetch stage and the writeback/flag logic.

## Interface

- WIDTH, 8, operand/result width in bits (>= 1)
- CNT_W, 4, width of the beat counter; saturates at 2^CNT_W-1

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- op  in  3  000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 PASS A
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- acc  in  1  beat belongs to an accumulate burst
- last  in  1  final beat of a burst (meaningful only with acc=1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y  out  WIDTH  result
- zero  out  1  y == 0
- ones  out  1  y == all ones
- beats  out  CNT_W  number of beats folded into y
- err  out  1  one-cycle pulse: accumulate burst aborted

## Operation

- One clock; reset is synchronous and active-low.
- Reset values: out_valid=0, y=0, zero=1, ones=0, beats=0, err=0, state=IDLE, accumulator=0.
- in_ready = !out_valid || out_ready, combinational, in every state.
- f(A,B) per op; NOT and PASS use A only.
- States:
  - IDLE: no burst open.
  - ACCUM: accumulator holds a partial result.
- IDLE, accepted beat with acc=0 (last ignored):
  - Result register loads f(a,b), beats=1.
  - Stays in IDLE.
- IDLE, accepted beat with acc=1:
  - last=1: single-beat burst. Output f(a,b), beats=1, stay in IDLE.
  - last=0: accumulator loads f(a,b), count=1, go to ACCUM. No output.
- ACCUM, accepted beat with acc=1:
  - Compute r=f(a, accumulator); b is ignored. op may differ per beat.
  - last=0: accumulator loads r, count increments (saturating). Stay in ACCUM.
  - last=1: output r with beats=count+1 (saturating), then go to IDLE.
- ACCUM, accepted beat with acc=0 (abort):
  - Accumulator is discarded and err pulses for one cycle.
  - The beat is processed as a plain IDLE acc=0 beat (output f(a,b), beats=1).
  - Go to IDLE.
- zero/ones are registered together with y and are meaningful only while out_valid=1.
- All arithmetic is bitwise at WIDTH; there are no carries.

## Timing

- Latency: an accepted output-producing beat at edge N gives out_valid=1 after edge N.
- Non-last accumulate beats produce no output.
- Throughput: one beat per cycle while out_ready=1.
- Stall (out_valid && !out_ready):
  - y, zero, ones, beats are held stable; in_ready=0.
  - The accumulator and state do not change.
- out_valid falls after the edge where out_ready=1, unless a new output-producing beat is accepted at the same edge. In that case out_valid stays 1 and the new result is loaded.
- Reset takes priority over everything at the edge where rst_n=0:
  - An open burst is dropped silently (no err).
  - A pending result is lost.
- err aligns with out_valid of the aborting beat.

## Test plan

- Reset: hold rst_n=0 for 2 cycles, out_ready=1 -> out_valid=0, y=0x00, zero=1, ones=0, beats=0, in_ready=1.
- Plain ops, back-to-back, a=0xF0, b=0x3C, op 0..7 -> y = 0x30, 0xFC, 0xCC, 0xCF, 0x03, 0x33, 0x0F, 0xF0 on consecutive cycles, each 1 cycle after its input.
  - ones=0 throughout; zero=0 throughout.
- Accumulate AND:
  - Beats: (a=0xFF, b=0xF7, acc=1), then (a=0x7F, acc=1), then (a=0xFE, acc=1, last=1).
  - Required: no out_valid until after beat 3; then y=0x76, beats=3, err=0.
- Backpressure: out_ready=0 while y=0x30 valid -> in_ready=0 and y held for 5 cycles.
  - Raise out_ready -> queued beat (OR 0x0F|0xF0) appears next cycle with y=0xFF, ones=1.
- Abort: (a=0xAA, b=0xFF, acc=1), then (op=AND, a=0x00, b=0x00, acc=0).
  - Required: err=1 for one cycle with y=0x00, zero=1, beats=1, state IDLE.
- Reset mid-burst: two acc beats, then rst_n=0 for one cycle, then (a=0x0F, b=0xFF, op=AND, acc=1, last=1).
  - Required: y=0x0F, beats=1, err=0.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Operand/result bus of the pipelined logic unit.
// The operand-fetch side is the master; the logic unit is the slave.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic [CNT_W-1:0] beats;
    logic             err;

    modport master (
        output in_valid, op, a, b, acc, last, out_ready,
        input  in_ready, out_valid, y, zero, ones, beats, err
    );

    modport slave (
        input  in_valid, op, a, b, acc, last, out_ready,
        output in_ready, out_valid, y, zero, ones, beats, err
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a one-stage output register and an
// accumulate mode that folds a multi-beat burst into a single result.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_unit_pipe_if.slave   bus
);
    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic             zero_q, ones_q;

    logic             fire;
    logic             load;
    logic [WIDTH-1:0] f_ab;
    logic [WIDTH-1:0] f_acc;
    logic [CNT_W-1:0] cnt_inc;

    // Eight bitwise operations; NOT and PASS only look at the first operand.
    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = x & z;
            3'b001:  r = x | z;
            3'b010:  r = x ^ z;
            3'b011:  r = ~(x & z);
            3'b100:  r = ~(x | z);
            3'b101:  r = ~(x ^ z);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    // A result can be accepted whenever the output register is free or draining.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign fire         = bus.in_valid && bus.in_ready;
    assign f_ab         = logic_op(bus.op, bus.a, bus.b);
    assign f_acc        = logic_op(bus.op, bus.a, acc_q);
    assign cnt_inc      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // Burst FSM and result selection; nothing moves unless a beat is accepted.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        y_d     = y_q;
        beats_d = beats_q;
        err_d   = 1'b0;
        if (fire) begin
            case (state_q)
                IDLE: begin
                    if (bus.acc && !bus.last) begin
                        acc_d   = f_ab;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        load    = 1'b1;
                        y_d     = f_ab;
                        beats_d = CNT_W'(1);
                    end
                end
                default: begin
                    if (bus.acc) begin
                        if (bus.last) begin
                            load    = 1'b1;
                            y_d     = f_acc;
                            beats_d = cnt_inc;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            acc_d = f_acc;
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Plain beat inside a burst: drop the partial result and flag it.
                        load    = 1'b1;
                        y_d     = f_ab;
                        beats_d = CNT_W'(1);
                        err_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            endcase
        end
        out_valid_d = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    end

    // State, accumulator and output register; flags follow the value loaded into y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            zero_q      <= (y_d == '0);
            ones_q      <= &y_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.beats     = beats_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed test-plan scenarios with
// literal expectations plus randomized traffic against a transaction model.
module tb_logic_unit_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] y;
        logic [3:0] beats;
    } exp_t;

    exp_t       q[$];
    bit         open;
    logic [7:0] accv;
    int         cnt;
    bit         fresh;
    bit         fresh_err;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    function automatic logic [7:0] f(input logic [2:0] op, input logic [7:0] x, input logic [7:0] z);
        case (op)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] r, input int c, input bit e);
        exp_t t;
        t.y = r;
        t.beats = 4'((c > 15) ? 15 : c);
        q.push_back(t);
        fresh = 1;
        fresh_err = e;
    endtask

    // Transaction-level reference: processes the beat seen at this rising edge.
    task automatic model_edge();
        bit rdy;
        logic [7:0] r;
        if (!rst_n) begin
            q.delete();
            open = 0; cnt = 0; accv = '0; fresh = 0; fresh_err = 0;
            return;
        end
        rdy = (q.size() == 0) || bus.out_ready;
        fresh = 0;
        fresh_err = 0;
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && rdy) begin
            if (bus.acc && open) begin
                r = f(bus.op, bus.a, accv);
                if (bus.last) begin
                    push(r, cnt + 1, 0);
                    open = 0;
                end else begin
                    accv = r;
                    cnt = (cnt + 1 > 15) ? 15 : cnt + 1;
                end
            end else if (bus.acc) begin
                r = f(bus.op, bus.a, bus.b);
                if (bus.last) push(r, 1, 0);
                else begin
                    open = 1; accv = r; cnt = 1;
                end
            end else begin
                push(f(bus.op, bus.a, bus.b), 1, open);
                open = 0;
            end
        end
    endtask

    task automatic compare();
        bit ev;
        ev = (q.size() != 0);
        chk("out_valid", bus.out_valid, ev);
        chk("in_ready", bus.in_ready, !ev || bus.out_ready);
        chk("err", bus.err, fresh && fresh_err);
        if (ev) begin
            chk("y", bus.y, q[0].y);
            chk("beats", bus.beats, q[0].beats);
            chk("zero", bus.zero, q[0].y == 8'h00);
            chk("ones", bus.ones, q[0].y == 8'hFF);
        end
    endtask

    // One clock: model sees the edge, outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic last);
        bus.in_valid = 1'b1;
        bus.op = op; bus.a = a; bus.b = b; bus.acc = acc; bus.last = last;
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        tick();
    endtask

    logic [7:0] plain_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};

    initial begin
        bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.acc = 0; bus.last = 0;
        bus.out_ready = 1;
        rst_n = 0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y", bus.y, 8'h00);
        chk("rst_zero", bus.zero, 1);
        chk("rst_ones", bus.ones, 0);
        chk("rst_beats", bus.beats, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        rst_n = 1;

        // Plain ops back to back
        for (int i = 0; i < 8; i++) begin
            beat(3'(i), 8'hF0, 8'h3C, 0, 0);
            chk("plain_y", bus.y, plain_exp[i]);
            chk("plain_zero", bus.zero, 0);
            chk("plain_ones", bus.ones, 0);
        end
        idle();

        // Accumulate AND over three beats
        beat(3'd0, 8'hFF, 8'hF7, 1, 0);
        chk("accum_no_out1", bus.out_valid, 0);
        beat(3'd0, 8'h7F, 8'h00, 1, 0);
        chk("accum_no_out2", bus.out_valid, 0);
        beat(3'd0, 8'hFE, 8'h00, 1, 1);
        chk("accum_valid", bus.out_valid, 1);
        chk("accum_y", bus.y, 8'h76);
        chk("accum_beats", bus.beats, 3);
        chk("accum_err", bus.err, 0);
        idle();

        // Backpressure
        beat(3'd0, 8'hF0, 8'h3C, 0, 0);
        bus.out_ready = 0;
        bus.op = 3'd1; bus.a = 8'h0F; bus.b = 8'hF0; bus.acc = 0; bus.last = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_y", bus.y, 8'h30);
        end
        bus.out_ready = 1;
        tick();
        chk("unstall_y", bus.y, 8'hFF);
        chk("unstall_ones", bus.ones, 1);
        idle();

        // Abort
        beat(3'd0, 8'hAA, 8'hFF, 1, 0);
        beat(3'd0, 8'h00, 8'h00, 0, 0);
        chk("abort_err", bus.err, 1);
        chk("abort_y", bus.y, 8'h00);
        chk("abort_zero", bus.zero, 1);
        chk("abort_beats", bus.beats, 1);
        idle();
        chk("abort_err_pulse", bus.err, 0);

        // Reset mid-burst
        beat(3'd1, 8'h12, 8'h34, 1, 0);
        beat(3'd1, 8'h56, 8'h00, 1, 0);
        bus.in_valid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        beat(3'd0, 8'h0F, 8'hFF, 1, 1);
        chk("rstburst_y", bus.y, 8'h0F);
        chk("rstburst_beats", bus.beats, 1);
        chk("rstburst_err", bus.err, 0);
        idle();

        // Beat counter saturation with a long PASS burst
        for (int i = 0; i < 17; i++) beat(3'd7, 8'(i), 8'h00, 1, 0);
        beat(3'd2, 8'h5A, 8'h00, 1, 1);
        chk("sat_beats", bus.beats, 15);
        chk("sat_y", bus.y, 8'h5A ^ 8'd16);
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(299, 0) != 0);
            bus.in_valid = ($urandom_range(99, 0) < 70);
            bus.op = 3'($urandom);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.acc = ($urandom_range(99, 0) < 65);
            bus.last = ($urandom_range(99, 0) < 30);
            bus.out_ready = ($urandom_range(99, 0) < 75);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
